// File: rtl/dm_arbiter_pkg.sv
// Shared encodings and lane helpers for the data-memory arbiter.
// Wordmode, FSM state and owner encodings live here so every user agrees on them.
package dm_arbiter_pkg;

  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HS = 3'd1;
  localparam logic [2:0] WM_HU = 3'd2;
  localparam logic [2:0] WM_BS = 3'd3;
  localparam logic [2:0] WM_BU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  function automatic logic is_half(input logic [2:0] wm);
    return (wm == WM_HS) || (wm == WM_HU);
  endfunction

  function automatic logic is_byte(input logic [2:0] wm);
    return (wm == WM_BS) || (wm == WM_BU);
  endfunction

  // Unassigned encodings behave as word accesses.
  function automatic logic misaligned(input logic [2:0] wm, input logic [1:0] a);
    if (is_half(wm)) return a[0];
    if (is_byte(wm)) return 1'b0;
    return a != 2'b00;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] wm, input logic [1:0] a);
    if (is_half(wm)) return a[1] ? 4'b1100 : 4'b0011;
    if (is_byte(wm)) return 4'b0001 << a;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [2:0] wm, input logic [31:0] d);
    if (is_half(wm)) return {2{d[15:0]}};
    if (is_byte(wm)) return {4{d[7:0]}};
    return d;
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Selects the addressed lane of a RAM word and zero/sign-extends it to 32 bits.
module dm_lane_ext
  import dm_arbiter_pkg::*;
(
  input  logic [2:0]  wordmode_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_l;

  always_comb begin
    half   = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
    byte_l = raw_i[{addr_i, 3'b000} +: 8];
    case (wordmode_i)
      WM_HS:   data_o = {{16{half[15]}}, half};
      WM_HU:   data_o = {16'h0000, half};
      WM_BS:   data_o = {{24{byte_l[7]}}, byte_l};
      WM_BU:   data_o = {24'h000000, byte_l};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter between the MEM stage and a word-only DMA master in front of a
// single-port data RAM; sequences the access, shapes store lanes and extends load data.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [2:0]        cpu_wordmode_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_done_o,
  output logic              cpu_stall_o,
  output logic              cpu_exc_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [31:0]       dma_wdata_i,
  output logic [31:0]       dma_rdata_o,
  output logic              dma_done_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        wm_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [3:0]        cnt_q;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dma_rdata_q;

  logic        idle, acc, last_acc;
  logic        cpu_mis, cpu_pick, grant_cpu, grant_dma;
  logic [31:0] ext_data;

  // CPU is preferred unless it owned the previous access and the DMA is also waiting.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    acc       = (state_q == ST_ACC);
    last_acc  = acc && (we_q || (cnt_q == LastCnt));
    cpu_mis   = misaligned(cpu_wordmode_i, cpu_addr_i[1:0]);
    cpu_pick  = cpu_req_i && (!dma_req_i || (last_owner_q == OWN_DMA));
    grant_cpu = idle && cpu_pick && !cpu_mis;
    grant_dma = idle && dma_req_i && !cpu_pick;
  end

  dm_lane_ext u_lane_ext (
    .wordmode_i (wm_q),
    .addr_i     (addr_q[1:0]),
    .raw_i      (mem_rdata_i),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DMA;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wm_q         <= WM_WD;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= 4'd0;
          if (grant_cpu) begin
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_CPU;
            we_q         <= cpu_we_i;
            addr_q       <= cpu_addr_i;
            wm_q         <= cpu_wordmode_i;
            be_q         <= byte_en(cpu_wordmode_i, cpu_addr_i[1:0]);
            wdata_q      <= rep_wdata(cpu_wordmode_i, cpu_wdata_i);
            state_q      <= ST_ACC;
          end else if (grant_dma) begin
            owner_q      <= OWN_DMA;
            last_owner_q <= OWN_DMA;
            we_q         <= dma_we_i;
            addr_q       <= dma_addr_i;
            wm_q         <= WM_WD;
            be_q         <= 4'b1111;
            wdata_q      <= dma_wdata_i;
            state_q      <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (last_acc) begin
            state_q <= ST_DONE;
            if (!we_q) begin
              if (owner_q == OWN_CPU) cpu_rdata_q <= ext_data;
              else                    dma_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM strobes are decoded from state so a reset removes them within the same cycle.
  assign mem_en_o    = acc;
  assign mem_be_o    = (acc && we_q) ? be_q : 4'b0000;
  assign mem_addr_o  = acc ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata_o = (acc && we_q) ? wdata_q : '0;

  assign cpu_done_o  = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign dma_done_o  = (state_q == ST_DONE) && (owner_q == OWN_DMA);
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;

  assign cpu_exc_o   = !rst_i && idle && cpu_pick && cpu_mis;
  assign cpu_stall_o = !rst_i && cpu_req_i && !cpu_done_o && !cpu_exc_o;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scenario bench for dm_arbiter: a lane-aware RAM model plus a completion scoreboard.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0]  cpu_wordmode = WM_WD;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_stall, cpu_exc;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_dma;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mon_got;

  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  dm_arbiter #(.WAIT_CYCLES(WAIT), .ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_req_i      (cpu_req),
    .cpu_we_i       (cpu_we),
    .cpu_addr_i     (cpu_addr),
    .cpu_wordmode_i (cpu_wordmode),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_rdata_o    (cpu_rdata),
    .cpu_done_o     (cpu_done),
    .cpu_stall_o    (cpu_stall),
    .cpu_exc_o      (cpu_exc),
    .dma_req_i      (dma_req),
    .dma_we_i       (dma_we),
    .dma_addr_i     (dma_addr),
    .dma_wdata_i    (dma_wdata),
    .dma_rdata_o    (dma_rdata),
    .dma_done_o     (dma_done),
    .mem_en_o       (mem_en),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_en && mem_be != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (cpu_done || dma_done)) begin
      checks++;
      if (cpu_done && dma_done) begin
        errors++;
        $display("FAIL sb_both_done cpu_done=%b dma_done=%b required one-hot", cpu_done, dma_done);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done dma=%b required no completion", dma_done);
      end else begin
        mon_e = sb.pop_front();
        mon_got = dma_done ? dma_rdata : cpu_rdata;
        if (mon_e.is_dma != dma_done) begin
          errors++;
          $display("FAIL sb_owner got dma=%b required dma=%b", dma_done, mon_e.is_dma);
        end else if (mon_e.is_rd && mon_got !== mon_e.data) begin
          errors++;
          $display("FAIL sb_rdata dma=%b got %h required %h", dma_done, mon_got, mon_e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // cyc = index of the cycle (from the call) in which done pulses, -1 on timeout.
  task automatic wait_done(input bit is_dma, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if ((is_dma ? dma_done : cpu_done) === 1'b1) break;
      cyc++;
      if (cyc > 40) begin
        cyc = -1;
        break;
      end
    end
  endtask

  task automatic run_cpu(input logic we, input logic [2:0] wm, input logic [31:0] addr,
                         input logic [31:0] wdata, output int cyc);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_wordmode = wm;
    cpu_addr = addr;
    cpu_wdata = wdata;
    wait_done(1'b0, cyc);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_be, mem_addr, mem_wdata, cpu_rdata, dma_rdata, cpu_done, dma_done,
         cpu_stall, cpu_exc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b be=%b done=%b%b stall=%b exc=%b required all 0",
               mem_en, mem_be, cpu_done, dma_done, cpu_stall, cpu_exc);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_cpu_store;
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_wordmode = WM_BU;
    cpu_addr = 32'h0000_0013;
    cpu_wdata = 32'h0000_00AB;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    @(negedge clk);
    checks++;
    if ({cpu_stall, mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL store_c0 got stall,en=%b required 10", {cpu_stall, mem_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_be, mem_addr, mem_wdata, cpu_stall, cpu_done} !==
        {1'b1, 4'b1000, 32'h10, 32'hABAB_ABAB, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL store_acc got en=%b be=%b addr=%h wd=%h stall=%b done=%b required 1 1000 10 ababab ab 1 0",
               mem_en, mem_be, mem_addr, mem_wdata, cpu_stall, cpu_done);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({cpu_done, cpu_stall, mem_en, mem_be} !== 7'b1000000) begin
      errors++;
      $display("FAIL store_done got done=%b stall=%b en=%b be=%b required 1 0 0 0000",
               cpu_done, cpu_stall, mem_en, mem_be);
    end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_stall, ram[4]} !== {1'b0, 32'hAB00_0000}) begin
      errors++;
      $display("FAIL store_ram got stall=%b word=%h required 0 ab000000", cpu_stall, ram[4]);
    end
    tick();
  endtask

  task automatic test_cpu_loads;
    int cyc;
    logic [2:0]  wms  [4] = '{WM_HS, WM_HU, WM_BS, WM_WD};
    logic [31:0] adrs [4] = '{32'h22, 32'h22, 32'h20, 32'h20};
    logic [31:0] exps [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFFF, 32'h8001_7FFF};
    ram[8] = 32'h8001_7FFF;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{1'b0, 1'b1, exps[i]});
      run_cpu(1'b0, wms[i], adrs[i], 32'h0, cyc);
      checks++;
      if (cyc != WAIT + 1) begin
        errors++;
        $display("FAIL load_latency case %0d got %0d required %0d", i, cyc, WAIT + 1);
      end
    end
    // Halfword store to the upper lane.
    ram[12] = 32'h0;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    run_cpu(1'b1, WM_HU, 32'h32, 32'h0000_1234, cyc);
    checks++;
    if ({cyc, ram[12]} !== {32'd2, 32'h1234_0000}) begin
      errors++;
      $display("FAIL half_store got lat=%0d word=%h required 2 12340000", cyc, ram[12]);
    end
  endtask

  task automatic test_misaligned;
    int cyc;
    logic        seen;
    logic [2:0]  wms  [2] = '{WM_WD, WM_HS};
    logic [31:0] adrs [2] = '{32'h06, 32'h21};
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_wordmode = wms[i];
      cpu_addr = adrs[i];
      @(negedge clk);
      checks++;
      if ({cpu_exc, cpu_stall, mem_en} !== 3'b100) begin
        errors++;
        $display("FAIL exc_pulse case %0d got exc,stall,en=%b required 100", i,
                 {cpu_exc, cpu_stall, mem_en});
      end
      tick();
      cpu_req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (mem_en || cpu_exc || cpu_done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL exc_no_access case %0d got activity=%b required 0", i, seen);
      end
      tick();
    end
    sb.push_back('{1'b0, 1'b1, 32'h0000_0080});
    run_cpu(1'b0, WM_BU, 32'h23, 32'h0, cyc);
    checks++;
    if (cyc != WAIT + 1) begin
      errors++;
      $display("FAIL byte_after_exc latency got %0d required %0d", cyc, WAIT + 1);
    end
  endtask

  task automatic test_back_to_back;
    logic got;
    apply_reset();
    ram[16] = 32'h1111_1111;
    ram[17] = 32'h2222_2222;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{(k % 2 == 1), 1'b1, (k % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111});
    end
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_wordmode = WM_WD;
    cpu_addr = 32'h40;
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_addr = 32'h44;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (cpu_done || dma_done) got = 1'b1;
      end
      checks++;
      if (!got || dma_done !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL rr_order grant %0d got done=%b dma=%b required dma=%0d", k, got,
                 dma_done, k % 2);
      end
      if (k == 3) begin
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end else begin
        @(negedge clk);
        checks++;
        if ({mem_en, cpu_done, dma_done} !== 3'b000) begin
          errors++;
          $display("FAIL rr_idle_gap after %0d got en,cd,dd=%b required 000", k,
                   {mem_en, cpu_done, dma_done});
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_access;
    int cyc;
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_addr = 32'h44;
    tick();
    tick();
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_acc_en got %b required 1", mem_en);
    end
    rst = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_wordmode = WM_WD;
    cpu_addr = 32'h40;
    #1;
    checks++;
    if ({mem_en, mem_be, mem_addr, mem_wdata, cpu_rdata, dma_rdata, cpu_done, dma_done,
         cpu_stall, cpu_exc} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got en=%b dr=%h cr=%h stall=%b required all 0",
               mem_en, dma_rdata, cpu_rdata, cpu_stall);
    end
    tick();
    rst = 1'b0;
    sb.push_back('{1'b0, 1'b1, 32'h1111_1111});
    sb.push_back('{1'b1, 1'b1, 32'h2222_2222});
    wait_done(1'b0, cyc);
    checks++;
    if (cyc != WAIT + 1) begin
      errors++;
      $display("FAIL post_reset_cpu_first latency got %0d required %0d", cyc, WAIT + 1);
    end
    tick();
    cpu_req = 1'b0;
    wait_done(1'b1, cyc);
    checks++;
    if (cyc != WAIT + 1) begin
      errors++;
      $display("FAIL post_reset_dma_next latency got %0d required %0d", cyc, WAIT + 1);
    end
    tick();
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_dma_write;
    int cyc;
    dma_req = 1'b1;
    dma_we = 1'b1;
    dma_addr = 32'h103;
    dma_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    @(negedge clk);
    checks++;
    if ({cpu_stall, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL dma_c0 got stall,en=%b required 00", {cpu_stall, mem_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_be, mem_addr, mem_wdata, cpu_stall} !==
        {1'b1, 4'b1111, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL dma_acc got en=%b be=%b addr=%h wd=%h stall=%b required 1 1111 100 deadbeef 0",
               mem_en, mem_be, mem_addr, mem_wdata, cpu_stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({dma_done, cpu_stall, mem_en} !== 3'b100) begin
      errors++;
      $display("FAIL dma_done got done,stall,en=%b required 100", {dma_done, cpu_stall, mem_en});
    end
    tick();
    dma_req = 1'b0;
    checks++;
    if (ram[64] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dma_ram got %h required deadbeef", ram[64]);
    end
    tick();
    sb.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_addr = 32'h100;
    wait_done(1'b1, cyc);
    checks++;
    if (cyc != WAIT + 1) begin
      errors++;
      $display("FAIL dma_read latency got %0d required %0d", cyc, WAIT + 1);
    end
    tick();
    dma_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    tick();
    test_reset();
    test_cpu_store();
    test_cpu_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_dma_write();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d outstanding required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Data-memory access controller sitting between the MEM pipeline stage, a secondary word-only master (DMA/debug loader), and the single-port data RAM.
- Arbitrates the two requesters round-robin and sequences a multi-cycle RAM access.
- Generates byte enables and lane-replicated write data, and sign/zero-extends load data.
- Stalls the pipeline while a CPU access is outstanding.

Parameters:
- WAIT_CYCLES, 2, RAM read latency in cycles; legal range 1..15.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM-stage access request; held until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address
- cpu_wordmode  in  3  access size/sign; encodings are the shared wm_* constants
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  extended load data; valid when cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  pipeline freeze
- cpu_exc  out  1  one-cycle misalignment pulse; no RAM access is made
- dma_req  in  1  word request; held until dma_done
- dma_we  in  1  1 = write
- dma_addr  in  ADDR_W  word address; bits [1:0] ignored
- dma_wdata  in  32  write data
- dma_rdata  out  32  read data; valid when dma_done=1
- dma_done  out  1  one-cycle completion pulse
- mem_en  out  1  RAM enable
- mem_be  out  4  byte write enables; 0000 on reads
- mem_addr  out  ADDR_W  word-aligned address ([1:0]=0)
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  RAM read data

Behaviour:
- Reset (async): state=IDLE, last_owner=DMA, wait counter 0, latched request cleared.
  - All outputs 0, including mem_en, mem_be, cpu_stall, cpu_done, dma_done, cpu_exc, cpu_rdata, dma_rdata.
  - A reset mid-access aborts the access. mem_be drops immediately, so no partial write is issued after reset asserts.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - Grant goes to cpu_req if only it is high, to dma_req if only it is high.
  - If both are high, grant goes to the master that is not last_owner. After reset this means the CPU wins first.
  - A CPU request with halfword mode and addr[0]=1, or word mode and addr[1:0]!=0, pulses cpu_exc for one cycle and stays in IDLE. last_owner is unchanged.
  - On a valid grant: latch owner, we, addr, wordmode and wdata; set last_owner=owner; go to ACC.
- ACC:
  - mem_en=1 and mem_addr={addr[ADDR_W-1:2],2'b00} for every ACC cycle.
  - Write: mem_be is asserted for exactly 1 cycle, then go to DONE.
  - Read: stay WAIT_CYCLES cycles; mem_rdata is captured on the last ACC cycle, then go to DONE.
- DONE (1 cycle):
  - Pulse the owner's done signal; its rdata register holds the result.
  - Return to IDLE. Arbitration resumes the next cycle, so there is no back-to-back grant in DONE.
- Byte enables:
  - Word: 1111.
  - Halfword: 0011 if addr[1]=0, else 1100.
  - Byte: one-hot (1 << addr[1:0]).
  - DMA accesses are always word.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Halfword: {2{wdata[15:0]}}.
  - Word: unchanged.
- Load extension:
  - The selected lane is shifted to bits [7:0] or [15:0].
  - hu and bu zero-extend; hs and bs sign-extend; wd passes through.
- cpu_stall:
  - Combinational: cpu_req & ~cpu_done & ~cpu_exc.
  - So it is high while the CPU waits for grant or access, and low in its DONE cycle and its exception cycle.
- Latency, uncontended: request in cycle 0 → done in cycle 2 for a write, in cycle WAIT_CYCLES+1 for a read.
- Requests are sampled only in IDLE. Changing inputs during ACC or DONE has no effect.
- A request dropped before grant is simply not served.

Decomposition:
- Shared header (same one holding the wm_* wordmode encodings) adds:
  - state encodings ST_IDLE, ST_ACC, ST_DONE;
  - owner encodings OWN_CPU, OWN_DMA.
- Sub-module dm_lane_ext: purely combinational (wordmode, addr[1:0], raw word) → extended load data. It is instantiated once on the captured read data.
- Byte-enable, write replication and FSM logic stay in dm_arbiter.

Test Plan:
- Reset, then CPU store, wm_bu, addr 0x0000_0013, wdata 0x0000_00AB → one ACC cycle with mem_be=1000, mem_addr=0x10, mem_wdata=0xABABABAB; cpu_done in cycle 2; cpu_stall high in cycles 0–1 only.
- CPU load, wm_hs, addr 0x22, RAM word 0x8001_7FFF, WAIT_CYCLES=2 → cpu_rdata=0xFFFF_8001 on cycle 3. Repeat with wm_hu → 0x0000_8001. Repeat with wm_bs at addr 0x20 → 0xFFFF_FFFF.
- cpu_req and dma_req both asserted continuously right after reset → grant order CPU, DMA, CPU, DMA. Each done pulse is followed by one IDLE cycle.
- CPU load, wm_wd, addr 0x0000_0006 → cpu_exc pulse in cycle 0; mem_en never asserted; state stays IDLE.
- Assert reset during the second ACC cycle of a DMA read → all outputs 0 immediately. After release, a pending CPU request wins first (last_owner=DMA).
- DMA write addr 0x103, data 0xDEADBEEF → mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; dma_done one cycle later; cpu_stall low throughout when cpu_req=0.
